// File: rtl/eth_hdr_extractor_pkg.sv
// Shared definitions for the Ethernet/IPv4 header extractor: header word
// indices, protocol constants, FSM state encoding and the captured header record.
package acl_hdr_pkg;

    // Beat index within the frame at which each header field arrives
    localparam logic [15:0] IDX_DST_HI            = 16'd0;
    localparam logic [15:0] IDX_DST_LO_SRC_HI     = 16'd1;
    localparam logic [15:0] IDX_SRC_LO            = 16'd2;
    localparam logic [15:0] IDX_ETYPE             = 16'd3;
    localparam logic [15:0] IDX_PROTO             = 16'd5;
    localparam logic [15:0] IDX_IPSRC_HI          = 16'd6;
    localparam logic [15:0] IDX_IPSRC_LO_IPDST_HI = 16'd7;
    localparam logic [15:0] IDX_IPDST_LO          = 16'd8;

    localparam logic [15:0] HDR_WORDS      = 16'd9;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_TCP   = 8'h06;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_HOLD,
        ST_PAYLOAD,
        ST_SKIP
    } state_t;

    typedef struct packed {
        logic [47:0] mac_dst;
        logic [47:0] mac_src;
        logic [15:0] ethertype;
        logic [7:0]  ip_proto;
        logic [31:0] ip_src;
        logic [31:0] ip_dst;
    } hdr_t;

    // Beat counter increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Merge one header beat into the field record according to its index
    function automatic hdr_t hdr_capture(input hdr_t h, input logic [15:0] idx,
                                         input logic [31:0] d);
        hdr_t r;
        r = h;
        case (idx)
            IDX_DST_HI:            r.mac_dst[47:16] = d;
            IDX_DST_LO_SRC_HI: begin
                r.mac_dst[15:0]  = d[31:16];
                r.mac_src[47:32] = d[15:0];
            end
            IDX_SRC_LO:            r.mac_src[31:0] = d;
            IDX_ETYPE:             r.ethertype = d[31:16];
            IDX_PROTO:             r.ip_proto = d[7:0];
            IDX_IPSRC_HI:          r.ip_src[31:16] = d[15:0];
            IDX_IPSRC_LO_IPDST_HI: begin
                r.ip_src[15:0]  = d[31:16];
                r.ip_dst[31:16] = d[15:0];
            end
            IDX_IPDST_LO:          r.ip_dst[15:0] = d[31:16];
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/eth_hdr_extractor_if.sv
// Receive stream plus extracted-header handshake of the header extractor.
// The slave modport is the extractor's view, master is the source/consumer side.
interface eth_hdr_extractor_if;
    logic [31:0] i_rxd_tdata;
    logic        i_rxd_tvalid;
    logic        i_rxd_tlast;
    logic        o_rxd_tready;
    logic        o_hdr_valid;
    logic        i_hdr_ready;
    logic [47:0] o_mac_dst;
    logic [47:0] o_mac_src;
    logic [15:0] o_ethertype;
    logic [7:0]  o_ip_proto;
    logic [31:0] o_ip_src;
    logic [31:0] o_ip_dst;
    logic        o_is_ipv4_tcp;
    logic        o_frame_done;
    logic        o_runt_err;
    logic        o_oversize_err;

    modport slave (
        input  i_rxd_tdata, i_rxd_tvalid, i_rxd_tlast, i_hdr_ready,
        output o_rxd_tready, o_hdr_valid, o_mac_dst, o_mac_src, o_ethertype,
               o_ip_proto, o_ip_src, o_ip_dst, o_is_ipv4_tcp, o_frame_done,
               o_runt_err, o_oversize_err
    );

    modport master (
        output i_rxd_tdata, i_rxd_tvalid, i_rxd_tlast, i_hdr_ready,
        input  o_rxd_tready, o_hdr_valid, o_mac_dst, o_mac_src, o_ethertype,
               o_ip_proto, o_ip_src, o_ip_dst, o_is_ipv4_tcp, o_frame_done,
               o_runt_err, o_oversize_err
    );
endinterface

// File: rtl/eth_hdr_extractor.sv
// Ethernet + IPv4 header extractor. Captures MAC/ethertype/IP fields from the
// first nine 32-bit beats of a frame, presents them with a valid/ready
// handshake while stalling the stream, then passes over the payload.
// Flags runt (ends inside header) and oversize (too many beats) frames.
module eth_hdr_extractor
    import acl_hdr_pkg::*;
#(
    parameter int MAX_LEN_WORDS = 380
) (
    input  logic               clk,
    input  logic               rst,
    eth_hdr_extractor_if.slave bus
);

    localparam logic [15:0] MAX_CNT = 16'(MAX_LEN_WORDS);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    hdr_t        hdr_q, hdr_d;
    logic        last8_q, last8_d;   // index 8 carried tlast: frame ends at HOLD exit
    logic        tready_q, tready_d;
    logic        runt_q, runt_d;
    logic        ovs_q, ovs_d;
    logic        done_q, done_d;
    logic        acc;

    // Next-state, counter, field capture and pulse generation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        last8_d = last8_q;
        runt_d  = 1'b0;
        ovs_d   = 1'b0;
        done_d  = 1'b0;
        acc     = bus.i_rxd_tvalid & tready_q;

        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    hdr_d = hdr_capture(hdr_q, IDX_DST_HI, bus.i_rxd_tdata);
                    if (bus.i_rxd_tlast) begin
                        runt_d = 1'b1;
                    end else begin
                        cnt_d   = 16'd1;
                        state_d = ST_HDR;
                    end
                end
            end
            ST_HDR: begin
                if (acc) begin
                    hdr_d = hdr_capture(hdr_q, cnt_q, bus.i_rxd_tdata);
                    cnt_d = sat_inc(cnt_q);
                    if (cnt_q == HDR_WORDS - 16'd1) begin
                        state_d = ST_HOLD;
                        last8_d = bus.i_rxd_tlast;
                    end else if (bus.i_rxd_tlast) begin
                        runt_d  = 1'b1;
                        cnt_d   = 16'd0;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.i_hdr_ready) begin
                    if (last8_q) begin
                        done_d  = 1'b1;
                        cnt_d   = 16'd0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (acc) begin
                    cnt_d = sat_inc(cnt_q);
                    if (bus.i_rxd_tlast) begin
                        done_d  = 1'b1;
                        cnt_d   = 16'd0;
                        state_d = ST_IDLE;
                    end else if (cnt_d == MAX_CNT) begin
                        ovs_d   = 1'b1;
                        state_d = ST_SKIP;
                    end
                end
            end
            ST_SKIP: begin
                if (acc) begin
                    if (bus.i_rxd_tlast) begin
                        cnt_d   = 16'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
            end
            default: begin
                cnt_d   = 16'd0;
                state_d = ST_IDLE;
            end
        endcase

        // The stream is stalled exactly while the header is being offered
        tready_d = (state_d != ST_HOLD);
    end

    // State, counter, field and pulse registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 16'd0;
            hdr_q    <= '0;
            last8_q  <= 1'b0;
            tready_q <= 1'b0;
            runt_q   <= 1'b0;
            ovs_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hdr_q    <= hdr_d;
            last8_q  <= last8_d;
            tready_q <= tready_d;
            runt_q   <= runt_d;
            ovs_q    <= ovs_d;
            done_q   <= done_d;
        end
    end

    assign bus.o_rxd_tready   = tready_q;
    assign bus.o_hdr_valid    = (state_q == ST_HOLD);
    assign bus.o_mac_dst      = hdr_q.mac_dst;
    assign bus.o_mac_src      = hdr_q.mac_src;
    assign bus.o_ethertype    = hdr_q.ethertype;
    assign bus.o_ip_proto     = hdr_q.ip_proto;
    assign bus.o_ip_src       = hdr_q.ip_src;
    assign bus.o_ip_dst       = hdr_q.ip_dst;
    assign bus.o_is_ipv4_tcp  = (state_q == ST_HOLD) &&
                                (hdr_q.ethertype == ETHERTYPE_IPV4) &&
                                (hdr_q.ip_proto == IP_PROTO_TCP);
    assign bus.o_frame_done   = done_q;
    assign bus.o_runt_err     = runt_q;
    assign bus.o_oversize_err = ovs_q;

endmodule

// File: tb/tb_eth_hdr_extractor.sv
// Directed bench for eth_hdr_extractor: a default instance and a
// MAX_LEN_WORDS=20 instance share one stimulus driver selected by 'sel'.
module tb_eth_hdr_extractor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tdata;
    logic        tvalid, tlast, hdr_ready;
    logic        sel;

    always #5 clk = ~clk;

    eth_hdr_extractor_if ifa ();
    eth_hdr_extractor_if ifb ();

    assign ifa.i_rxd_tdata  = tdata;
    assign ifa.i_rxd_tvalid = tvalid & ~sel;
    assign ifa.i_rxd_tlast  = tlast;
    assign ifa.i_hdr_ready  = hdr_ready;
    assign ifb.i_rxd_tdata  = tdata;
    assign ifb.i_rxd_tvalid = tvalid & sel;
    assign ifb.i_rxd_tlast  = tlast;
    assign ifb.i_hdr_ready  = hdr_ready;

    eth_hdr_extractor u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    eth_hdr_extractor #(.MAX_LEN_WORDS(20)) u_dut20 (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    // Observed outputs of whichever instance is selected
    logic        m_tready, m_hv, m_tcp, m_done, m_runt, m_ovs;
    logic [47:0] m_mac_dst, m_mac_src;
    logic [15:0] m_etype;
    logic [7:0]  m_proto;
    logic [31:0] m_ipsrc, m_ipdst;

    assign m_tready  = sel ? ifb.o_rxd_tready   : ifa.o_rxd_tready;
    assign m_hv      = sel ? ifb.o_hdr_valid    : ifa.o_hdr_valid;
    assign m_tcp     = sel ? ifb.o_is_ipv4_tcp  : ifa.o_is_ipv4_tcp;
    assign m_done    = sel ? ifb.o_frame_done   : ifa.o_frame_done;
    assign m_runt    = sel ? ifb.o_runt_err     : ifa.o_runt_err;
    assign m_ovs     = sel ? ifb.o_oversize_err : ifa.o_oversize_err;
    assign m_mac_dst = sel ? ifb.o_mac_dst      : ifa.o_mac_dst;
    assign m_mac_src = sel ? ifb.o_mac_src      : ifa.o_mac_src;
    assign m_etype   = sel ? ifb.o_ethertype    : ifa.o_ethertype;
    assign m_proto   = sel ? ifb.o_ip_proto     : ifa.o_ip_proto;
    assign m_ipsrc   = sel ? ifb.o_ip_src       : ifa.o_ip_src;
    assign m_ipdst   = sel ? ifb.o_ip_dst       : ifa.o_ip_dst;

    int n_cmp = 0;
    int n_err = 0;

    // Event monitor: counts pulses, accepted beats and header-valid cycles
    int   cyc = 0, n_done = 0, n_runt = 0, n_ovs = 0, n_hv = 0, n_hv_rdy = 0;
    int   n_acc = 0, bif = 0, acc8 = -100, hv_rise = -200, ovs_at = -1;
    logic last_tcp = 1'b0, hv_prev = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (m_done) n_done++;
        if (m_runt) n_runt++;
        if (m_ovs) begin
            n_ovs++;
            ovs_at = bif;
        end
        if (m_hv) begin
            n_hv++;
            last_tcp = m_tcp;
            if (m_tready) n_hv_rdy++;
        end
        if (m_hv && !hv_prev) hv_rise = cyc;
        hv_prev = m_hv;
        if (rst) begin
            bif = 0;
        end else if (tvalid && m_tready) begin
            n_acc++;
            if (bif == 8) acc8 = cyc;
            bif = tlast ? 0 : bif + 1;
        end
    end

    int s_done, s_runt, s_ovs, s_hv, s_hvr, s_acc;

    task automatic snap();
        s_done = n_done; s_runt = n_runt; s_ovs = n_ovs;
        s_hv = n_hv; s_hvr = n_hv_rdy; s_acc = n_acc;
    endtask

    logic [31:0] fr [0:127];

    task automatic build_std(input int payload, input logic [31:0] etw);
        fr[0] = 32'h8000207A; fr[1] = 32'h3F3E8000; fr[2] = 32'h20203AAE;
        fr[3] = etw;          fr[4] = 32'hBBBBBBBB; fr[5] = 32'hCCCC9906;
        fr[6] = 32'hDDDDC0A8; fr[7] = 32'h0101C0A8; fr[8] = 32'h0202CCCC;
        for (int k = 0; k < payload; k++) fr[9 + k] = 32'hA5000000 | k;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last, input int gap);
        int w;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            tvalid = 1'b0;
        end
        @(negedge clk);
        tdata = d; tlast = last; tvalid = 1'b1;
        w = 0;
        while (!m_tready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) begin
            n_cmp++; n_err++;
            $display("FAIL beat_timeout: tready stayed %b for %0d cycles, required 1", m_tready, w);
        end
        @(posedge clk);
    endtask

    task automatic send_frame(input int n, input bit gaps);
        for (int i = 0; i < n; i++)
            send_beat(fr[i], (i == n - 1), gaps ? int'($urandom_range(0, 1)) : 0);
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (m_tready !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b required 0", m_tready); end
        n_cmp++; if (m_hv !== 1'b0) begin n_err++; $display("FAIL rst_hdr_valid: got %b required 0", m_hv); end
        n_cmp++; if ({m_done, m_runt, m_ovs} !== 3'b000) begin n_err++; $display("FAIL rst_pulses: got %b required 000", {m_done, m_runt, m_ovs}); end
        n_cmp++; if ({m_mac_dst, m_mac_src, m_etype, m_proto, m_ipsrc, m_ipdst} !== 184'd0) begin n_err++; $display("FAIL rst_fields: got %h required 0", {m_mac_dst, m_ipdst}); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (m_tready !== 1'b1) begin n_err++; $display("FAIL post_rst_tready: got %b required 1", m_tready); end
    endtask

    task automatic check_std_fields(input string tag);
        n_cmp++; if (m_mac_dst !== 48'h8000207A3F3E) begin n_err++; $display("FAIL %s_mac_dst: got %h required 8000207a3f3e", tag, m_mac_dst); end
        n_cmp++; if (m_mac_src !== 48'h800020203AAE) begin n_err++; $display("FAIL %s_mac_src: got %h required 800020203aae", tag, m_mac_src); end
        n_cmp++; if (m_proto !== 8'h06) begin n_err++; $display("FAIL %s_proto: got %h required 06", tag, m_proto); end
        n_cmp++; if (m_ipsrc !== 32'hC0A80101) begin n_err++; $display("FAIL %s_ip_src: got %h required c0a80101", tag, m_ipsrc); end
        n_cmp++; if (m_ipdst !== 32'hC0A80202) begin n_err++; $display("FAIL %s_ip_dst: got %h required c0a80202", tag, m_ipdst); end
    endtask

    task automatic test_ipv4_tcp(input bit gaps, input string tag);
        hdr_ready = 1'b1;
        build_std(90, 32'h08004500);
        snap();
        send_frame(99, gaps);
        check_std_fields(tag);
        n_cmp++; if (m_etype !== 16'h0800) begin n_err++; $display("FAIL %s_ethertype: got %h required 0800", tag, m_etype); end
        n_cmp++; if (last_tcp !== 1'b1) begin n_err++; $display("FAIL %s_is_tcp: got %b required 1", tag, last_tcp); end
        n_cmp++; if (n_done - s_done !== 1) begin n_err++; $display("FAIL %s_done_count: got %0d required 1", tag, n_done - s_done); end
        n_cmp++; if (n_hv - s_hv !== 1) begin n_err++; $display("FAIL %s_hv_cycles: got %0d required 1", tag, n_hv - s_hv); end
        n_cmp++; if (n_acc - s_acc !== 99) begin n_err++; $display("FAIL %s_accepted: got %0d required 99", tag, n_acc - s_acc); end
        n_cmp++; if ((n_runt - s_runt) + (n_ovs - s_ovs) !== 0) begin n_err++; $display("FAIL %s_errors: got %0d required 0", tag, (n_runt - s_runt) + (n_ovs - s_ovs)); end
        n_cmp++; if (hv_rise - acc8 !== 1) begin n_err++; $display("FAIL %s_hdr_latency: got %0d required 1", tag, hv_rise - acc8); end
    endtask

    task automatic test_hold();
        int w;
        build_std(90, 32'h0700AAAA);
        hdr_ready = 1'b0;
        snap();
        fork
            send_frame(99, 1'b0);
            begin
                w = 0;
                while (!m_hv && w < 500) begin
                    @(negedge clk);
                    w++;
                end
                if (w >= 500) begin
                    n_cmp++; n_err++;
                    $display("FAIL hold_wait: hdr_valid got %b after %0d cycles, required 1", m_hv, w);
                end
                repeat (9) @(negedge clk);
                hdr_ready = 1'b1;
            end
        join
        n_cmp++; if (n_hv - s_hv !== 10) begin n_err++; $display("FAIL hold_hv_cycles: got %0d required 10", n_hv - s_hv); end
        n_cmp++; if (n_hv_rdy - s_hvr !== 0) begin n_err++; $display("FAIL hold_tready: got %0d ready cycles required 0", n_hv_rdy - s_hvr); end
        n_cmp++; if (last_tcp !== 1'b0) begin n_err++; $display("FAIL hold_is_tcp: got %b required 0", last_tcp); end
        n_cmp++; if (m_etype !== 16'h0700) begin n_err++; $display("FAIL hold_ethertype: got %h required 0700", m_etype); end
        n_cmp++; if (n_acc - s_acc !== 99) begin n_err++; $display("FAIL hold_accepted: got %0d required 99", n_acc - s_acc); end
        n_cmp++; if (n_done - s_done !== 1) begin n_err++; $display("FAIL hold_done: got %0d required 1", n_done - s_done); end
    endtask

    task automatic test_runt();
        build_std(0, 32'h08004500);
        snap();
        send_frame(5, 1'b0);
        n_cmp++; if (n_runt - s_runt !== 1) begin n_err++; $display("FAIL runt5_count: got %0d required 1", n_runt - s_runt); end
        n_cmp++; if (n_hv - s_hv !== 0) begin n_err++; $display("FAIL runt5_hv: got %0d required 0", n_hv - s_hv); end
        n_cmp++; if (n_done - s_done !== 0) begin n_err++; $display("FAIL runt5_done: got %0d required 0", n_done - s_done); end
        snap();
        send_frame(1, 1'b0);
        n_cmp++; if (n_runt - s_runt !== 1) begin n_err++; $display("FAIL runt1_count: got %0d required 1", n_runt - s_runt); end
        n_cmp++; if (n_done - s_done !== 0) begin n_err++; $display("FAIL runt1_done: got %0d required 0", n_done - s_done); end
    endtask

    task automatic test_oversize();
        sel = 1'b1;
        hdr_ready = 1'b1;
        @(negedge clk);
        build_std(21, 32'h08004500);
        snap();
        send_frame(30, 1'b0);
        n_cmp++; if (n_ovs - s_ovs !== 1) begin n_err++; $display("FAIL ovs_count: got %0d required 1", n_ovs - s_ovs); end
        n_cmp++; if (ovs_at !== 20) begin n_err++; $display("FAIL ovs_position: got %0d required 20", ovs_at); end
        n_cmp++; if (n_acc - s_acc !== 30) begin n_err++; $display("FAIL ovs_accepted: got %0d required 30", n_acc - s_acc); end
        n_cmp++; if (n_done - s_done !== 0) begin n_err++; $display("FAIL ovs_done: got %0d required 0", n_done - s_done); end
        build_std(5, 32'h08004500);
        fr[2] = 32'h11223344;
        snap();
        send_frame(14, 1'b0);
        n_cmp++; if (n_done - s_done !== 1) begin n_err++; $display("FAIL ovs_next_done: got %0d required 1", n_done - s_done); end
        n_cmp++; if (m_mac_src !== 48'h800011223344) begin n_err++; $display("FAIL ovs_next_mac_src: got %h required 800011223344", m_mac_src); end
        n_cmp++; if (last_tcp !== 1'b1) begin n_err++; $display("FAIL ovs_next_is_tcp: got %b required 1", last_tcp); end
        n_cmp++; if (n_ovs - s_ovs !== 0) begin n_err++; $display("FAIL ovs_next_ovs: got %0d required 0", n_ovs - s_ovs); end
        sel = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        hdr_ready = 1'b1;
        build_std(90, 32'h08004500);
        snap();
        for (int i = 0; i < 49; i++) send_beat(fr[i], 1'b0, 0);
        @(negedge clk);
        tvalid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fr[0] = 32'h0A0B0C0D;
        fr[6] = 32'hDDDD0A00;
        fr[7] = 32'h00010A00;
        fr[8] = 32'h0002CCCC;
        send_frame(20, 1'b0);
        n_cmp++; if (n_done - s_done !== 1) begin n_err++; $display("FAIL rstmid_done: got %0d required 1", n_done - s_done); end
        n_cmp++; if ((n_runt - s_runt) + (n_ovs - s_ovs) !== 0) begin n_err++; $display("FAIL rstmid_errors: got %0d required 0", (n_runt - s_runt) + (n_ovs - s_ovs)); end
        n_cmp++; if (m_mac_dst !== 48'h0A0B0C0D3F3E) begin n_err++; $display("FAIL rstmid_mac_dst: got %h required 0a0b0c0d3f3e", m_mac_dst); end
        n_cmp++; if (m_ipsrc !== 32'h0A000001) begin n_err++; $display("FAIL rstmid_ip_src: got %h required 0a000001", m_ipsrc); end
        n_cmp++; if (m_ipdst !== 32'h0A000002) begin n_err++; $display("FAIL rstmid_ip_dst: got %h required 0a000002", m_ipdst); end
        n_cmp++; if (last_tcp !== 1'b1) begin n_err++; $display("FAIL rstmid_is_tcp: got %b required 1", last_tcp); end
    endtask

    initial begin
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = 32'd0;
        hdr_ready = 1'b1; sel = 1'b0;
        test_reset();
        test_ipv4_tcp(1'b0, "tcp");
        test_hold();
        test_runt();
        test_oversize();
        test_reset_mid();
        test_ipv4_tcp(1'b1, "gaps");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/eth_hdr_extractor.md
ETH_HDR_EXTRACTOR -- requirements
Module: eth_hdr_extractor

Interface
REQ-001 SHALL have parameter MAX_LEN_WORDS, default 380, meaning frame-length limit in 32-bit beats; beyond this the frame is flagged oversize.
REQ-002 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 i_rxd_tdata  in  32  stream beat, first transmitted byte in [31:24].
REQ-005 i_rxd_tvalid  in  1  beat valid; i_rxd_tlast  in  1  last beat of frame.
REQ-006 o_rxd_tready  out  1  beat accepted when tvalid & tready high on the same edge.
REQ-007 o_hdr_valid  out  1  header fields valid, held until accepted; i_hdr_ready  in  1  consumer accepts header.
REQ-008 o_mac_dst, o_mac_src  out  48 each; o_ethertype  out  16; o_ip_proto  out  8; o_ip_src, o_ip_dst  out  32 each.
REQ-009 o_is_ipv4_tcp  out  1  ethertype==0x0800 and proto==0x06, qualified by o_hdr_valid.
REQ-010 o_frame_done  out  1  one-cycle pulse on acceptance of a tlast beat of a non-runt frame.
REQ-011 o_runt_err, o_oversize_err  out  1 each  one-cycle error pulses.

Function
REQ-012 Header word map (beat index n): 0 dst[47:16]; 1 dst[15:0]|src[47:32]; 2 src[31:0]; 3 ethertype[31:16]; 5 proto[7:0]; 6 ip_src[31:16] from [15:0]; 7 ip_src[15:0] from [31:16], ip_dst[31:16] from [15:0]; 8 ip_dst[15:0] from [31:16]; other bits ignored.
REQ-013 FSM states IDLE, HDR, HOLD, PAYLOAD, SKIP.
REQ-014 IDLE: tready=1; accepted beat is index 0, captured, go HDR (or, if tlast, runt: pulse o_runt_err, stay IDLE).
REQ-015 HDR: tready=1; beat counter increments per accepted beat; tlast before index 8 -> o_runt_err pulse next cycle, no o_hdr_valid, go IDLE.
REQ-016 Acceptance of index 8 -> HOLD next cycle; o_hdr_valid=1 and all field outputs stable while in HOLD.
REQ-017 HOLD: tready=0; on i_hdr_ready=1, o_hdr_valid drops next cycle and go PAYLOAD, or IDLE with o_frame_done pulse if index 8 carried tlast.
REQ-018 PAYLOAD: tready=1; tlast accepted -> o_frame_done pulse next cycle, go IDLE.
REQ-019 Beat count is 16-bit, saturating at 0xFFFF, cleared on entry to IDLE.
REQ-020 Beat count reaching MAX_LEN_WORDS without tlast -> o_oversize_err pulse, go SKIP; SKIP: tready=1, discard until tlast, then IDLE with no o_frame_done.
REQ-021 tvalid low in any state SHALL not advance counter or state; gaps of any length are legal.
REQ-022 Header latency: o_hdr_valid rises exactly one cycle after acceptance of index 8.
REQ-023 Field registers update only on accepted beats in IDLE/HDR; no change in HOLD.

Reset
REQ-024 On rst=1 at a clock edge: state IDLE, counter 0, all fields 0, o_hdr_valid/o_frame_done/errors 0, o_rxd_tready 0 during the reset cycle, 1 on the first cycle after.
REQ-025 rst mid-frame (any state) SHALL abandon the frame with no pulses; following beats start a new frame at index 0.

Structure
REQ-026 Shared package acl_hdr_pkg SHALL hold: header word-index constants, HDR_WORDS=9, ETHERTYPE_IPV4=16'h0800, IP_PROTO_TCP=8'h06, FSM state enum, and packed struct hdr_t of all field outputs.
REQ-027 Single module, no sub-module; est. 150-250 lines.

Verification
REQ-028 9-word header 8000207A,3F3E8000,20203AAE,08004500,BBBBBBBB,CCCC9906,DDDDC0A8,0101C0A8,0202CCCC + 90 payload beats, i_hdr_ready tied 1 -> mac_dst 8000207A3F3E, mac_src 800020203AAE, ethertype 0800, proto 06, ip_src C0A80101, ip_dst C0A80202, is_ipv4_tcp=1, one o_frame_done.
REQ-029 Same frame with ethertype word 0700AAAA, i_hdr_ready held 0 for 10 cycles -> o_hdr_valid high 10 cycles, tready 0 throughout, is_ipv4_tcp=0, no payload beat lost.
REQ-030 5-beat frame with tlast on beat 4 -> one o_runt_err, no o_hdr_valid, no o_frame_done.
REQ-031 MAX_LEN_WORDS=20, 30-beat frame -> o_oversize_err after beat 20, remaining beats accepted, no o_frame_done, next frame parsed normally.
REQ-032 rst asserted at payload beat 40, then clean frame -> no pulses from first frame, second frame fields correct.
REQ-033 Random tvalid gaps (50% duty) on REQ-028 frame -> identical field values and pulse counts.
